// File: rtl/countdown8_if.sv
// Control/status bundle for the countdown8 timer: load/start/enable/rate/data in,
// count and status pulses out.
interface countdown8_if;
   logic       Load;
   logic       Start;
   logic       Enable;
   logic [1:0] Rate;
   logic [7:0] D;
   logic [7:0] Q;
   logic       Busy;
   logic       Tick;
   logic       Done;

   modport master (
      output Load, Start, Enable, Rate, D,
      input  Q, Busy, Tick, Done
   );

   modport slave (
      input  Load, Start, Enable, Rate, D,
      output Q, Busy, Tick, Done
   );
endinterface

// File: rtl/countdown8.sv
// 8-bit loadable down-counter with a rate-selectable prescaler; pulses Tick on
// every decrement and Done on expiry.
module countdown8 #(
   parameter int unsigned TICK_BASE = 1,
   parameter int unsigned DIV_W     = 8
) (
   input logic         Clock,
   input logic         Clear_b,
   countdown8_if.slave bus
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [7:0]       q_q, q_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             tick_q, tick_d;
   logic             done_q, done_d;
   logic [DIV_W:0]   period;
   logic             tick_evt;

   // >= rather than == so a lowered Rate mid-count cannot strand div above P-1
   always_comb begin
      period   = (DIV_W+1)'(TICK_BASE) << bus.Rate;
      tick_evt = (state_q == RUN) && bus.Enable &&
                 ({1'b0, div_q} >= (period - (DIV_W+1)'(1)));
   end

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      div_d   = div_q;
      tick_d  = 1'b0;
      done_d  = 1'b0;
      if (bus.Load) begin
         q_d     = bus.D;
         div_d   = '0;
         state_d = IDLE;
      end else if (bus.Start && state_q == IDLE) begin
         if (q_q != 8'd0) begin
            state_d = RUN;
            div_d   = '0;
         end else begin
            done_d  = 1'b1;
         end
      end else if (tick_evt) begin
         div_d  = '0;
         q_d    = q_q - 8'd1;
         tick_d = 1'b1;
         if (q_q == 8'd1) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
      end else if (state_q == RUN && bus.Enable) begin
         div_d = div_q + DIV_W'(1);
      end
   end

   always_ff @(posedge Clock) begin
      if (!Clear_b) begin
         state_q <= IDLE;
         q_q     <= '0;
         div_q   <= '0;
         tick_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         div_q   <= div_d;
         tick_q  <= tick_d;
         done_q  <= done_d;
      end
   end

   assign bus.Q    = q_q;
   assign bus.Busy = (state_q == RUN);
   assign bus.Tick = tick_q;
   assign bus.Done = done_q;

endmodule

// File: tb/tb_countdown8.sv
// Self-checking bench for countdown8: directed scenarios plus randomized traffic
// against an integer-level behavioural model.
module tb_countdown8;

   localparam int unsigned TB_TICK = 1;
   localparam int unsigned TB_DIVW = 8;

   logic Clock;
   logic Clear_b;
   countdown8_if bus ();

   countdown8 #(.TICK_BASE(TB_TICK), .DIV_W(TB_DIVW)) dut (
      .Clock   (Clock),
      .Clear_b (Clear_b),
      .bus     (bus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural model: plain integers, running flag, cycles since last decrement
   int m_q    = 0;
   int m_div  = 0;
   bit m_run  = 0;
   bit m_tick = 0;
   bit m_done = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_step(input bit clr, input bit ld, input bit st,
                             input bit en, input int rate, input int d);
      int p;
      p      = TB_TICK * (1 << rate);
      m_tick = 0;
      m_done = 0;
      if (!clr) begin
         m_q = 0; m_div = 0; m_run = 0;
      end else if (ld) begin
         m_q = d; m_div = 0; m_run = 0;
      end else if (st && !m_run) begin
         if (m_q != 0) begin
            m_run = 1; m_div = 0;
         end else begin
            m_done = 1;
         end
      end else if (m_run && en) begin
         if (m_div >= p - 1) begin
            m_div  = 0;
            m_q    = m_q - 1;
            m_tick = 1;
            if (m_q == 0) begin
               m_run  = 0;
               m_done = 1;
            end
         end else begin
            m_div++;
         end
      end
   endtask

   task automatic cycle(input bit clr, input bit ld, input bit st, input bit en,
                        input int rate, input int d);
      Clear_b    = clr;
      bus.Load   = ld;
      bus.Start  = st;
      bus.Enable = en;
      bus.Rate   = 2'(rate);
      bus.D      = 8'(d);
      model_step(clr, ld, st, en, rate, d);
      @(posedge Clock);
      #1;
      check("q",    int'(bus.Q),    m_q);
      check("busy", int'(bus.Busy), int'(m_run));
      check("tick", int'(bus.Tick), int'(m_tick));
      check("done", int'(bus.Done), int'(m_done));
   endtask

   initial begin
      int ticks;
      int lat;
      bit seen;
      int frozen;
      int exp_q [5] = '{4, 3, 2, 1, 0};

      Clear_b = 1'b0; bus.Load = 1'b0; bus.Start = 1'b0; bus.Enable = 1'b0;
      bus.Rate = 2'd0; bus.D = 8'd0;

      // reset with other inputs active
      cycle(0, 1, 1, 1, 3, 8'h55);
      cycle(0, 0, 0, 0, 0, 0);
      check("rst_q", int'(bus.Q), 0);
      check("rst_busy", int'(bus.Busy), 0);

      // load 5, start at P=1
      cycle(1, 1, 0, 1, 0, 5);
      check("ld5_q", int'(bus.Q), 5);
      cycle(1, 0, 1, 1, 0, 0);
      check("start_busy", int'(bus.Busy), 1);
      ticks = 0;
      for (int i = 0; i < 5; i++) begin
         cycle(1, 0, 0, 1, 0, 0);
         check("p1_q", int'(bus.Q), exp_q[i]);
         if (bus.Tick) ticks++;
      end
      check("p1_ticks", ticks, 5);
      check("p1_done", int'(bus.Done), 1);
      cycle(1, 0, 0, 1, 0, 0);
      check("p1_busy_after", int'(bus.Busy), 0);
      check("p1_done_once", int'(bus.Done), 0);

      // load 3, P=4: Done 12 cycles after Start
      cycle(1, 1, 0, 1, 2, 3);
      cycle(1, 0, 1, 1, 2, 0);
      lat = 0; seen = 0;
      for (int i = 1; i <= 40 && !seen; i++) begin
         cycle(1, 0, 0, 1, 2, 0);
         if (bus.Done) begin seen = 1; lat = i; end
      end
      check("p4_done_seen", int'(seen), 1);
      check("p4_done_lat", lat, 12);

      // freeze with Enable low
      cycle(1, 1, 0, 1, 1, 8'h80);
      cycle(1, 0, 1, 1, 1, 0);
      for (int i = 0; i < 5; i++) cycle(1, 0, 0, 1, 1, 0);
      frozen = m_q;
      for (int i = 0; i < 10; i++) begin
         cycle(1, 0, 0, 0, 1, 0);
         check("hold_q", int'(bus.Q), frozen);
      end
      cycle(1, 0, 0, 1, 1, 0);
      cycle(1, 0, 0, 1, 1, 0);
      check("resume_q", int'(bus.Q), frozen - 1);

      // Load during RUN aborts without Done
      cycle(1, 1, 0, 1, 2, 7);
      cycle(1, 0, 1, 1, 2, 0);
      check("run7_q", int'(bus.Q), 7);
      cycle(1, 1, 0, 1, 2, 8'hFF);
      check("ldff_q", int'(bus.Q), 255);
      check("ldff_busy", int'(bus.Busy), 0);
      check("ldff_done", int'(bus.Done), 0);
      cycle(1, 0, 1, 1, 0, 0);
      cycle(1, 0, 0, 1, 0, 0);
      check("ff_count", int'(bus.Q), 254);

      // Start with Q==0
      cycle(1, 1, 0, 1, 0, 0);
      cycle(1, 0, 1, 1, 0, 0);
      check("z_done", int'(bus.Done), 1);
      check("z_busy", int'(bus.Busy), 0);
      cycle(1, 0, 0, 1, 0, 0);
      check("z_done_once", int'(bus.Done), 0);
      check("z_q", int'(bus.Q), 0);

      // reset beats Load mid-RUN
      cycle(1, 1, 0, 1, 0, 9);
      cycle(1, 0, 1, 1, 0, 0);
      cycle(1, 0, 0, 1, 0, 0);
      cycle(0, 1, 0, 1, 0, 8'hAA);
      check("clr_q", int'(bus.Q), 0);
      check("clr_busy", int'(bus.Busy), 0);
      check("clr_tick", int'(bus.Tick), 0);
      check("clr_done", int'(bus.Done), 0);

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         bit clr, ld, st, en;
         int rate, d;
         clr  = ($urandom_range(0, 99) >= 2);
         ld   = ($urandom_range(0, 99) < 6);
         st   = ($urandom_range(0, 99) < 20);
         en   = ($urandom_range(0, 99) < 85);
         rate = (i % 64 < 32) ? 0 : int'($urandom_range(0, 3));
         d    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 6))
                                            : int'($urandom_range(0, 255));
         cycle(clr, ld, st, en, rate, d);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
